// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop input synchronizer, oversampled majority-vote bit decode,
// optional parity check and stop-bit check, with one-cycle result pulses.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_sync1, r_sync2;
  logic [5:0]            r_edge_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [5:0]            r_presc;
  logic                  r_par_en, r_par_typ;
  logic                  r_par_flag;
  logic                  r_s0, r_s1;
  logic [DATA_WIDTH-1:0] r_shift;

  logic                  w_rx_s;
  logic [5:0]            w_half;
  logic                  w_dec;
  logic                  w_wrap;
  logic                  w_bit;
  logic                  w_par_exp;
  logic                  w_counting;

  assign w_rx_s     = r_sync2;
  assign w_half     = {1'b0, r_presc[5:1]};
  assign w_dec      = (r_edge_cnt == w_half + 6'd1);
  assign w_wrap     = (r_edge_cnt == r_presc - 6'd1);
  // Third vote is the live sample taken at the decision edge itself.
  assign w_bit      = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
  assign w_par_exp  = r_par_typ ? ~^r_shift : ^r_shift;
  assign w_counting = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_presc    <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_flag <= 1'b0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_shift    <= '0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      r_sync1    <= RX_IN;
      r_sync2    <= r_sync1;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;

      if (w_counting) begin
        r_edge_cnt <= w_wrap ? 6'd0 : r_edge_cnt + 6'd1;
        if (r_edge_cnt == w_half - 6'd1) r_s0 <= w_rx_s;
        if (r_edge_cnt == w_half)        r_s1 <= w_rx_s;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state    <= S_START;
            r_edge_cnt <= 6'd1;
            r_presc    <= PRESCALE;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_flag <= 1'b0;
            r_bit_cnt  <= '0;
          end
        end
        S_START: begin
          if (w_dec && w_bit) begin
            r_state <= S_IDLE;
          end else if (w_wrap) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (w_dec) r_shift[r_bit_cnt] <= w_bit;
          if (w_wrap) begin
            if (r_bit_cnt == BW'(DATA_WIDTH - 1))
              r_state <= r_par_en ? S_PARITY : S_STOP;
            else
              r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_dec)  r_par_flag <= (w_bit != w_par_exp);
          if (w_wrap) r_state <= S_STOP;
        end
        S_STOP: begin
          // Results are decided mid stop bit so the next start edge is never missed.
          if (w_dec) begin
            r_state    <= S_DONE;
            DATA_VALID <= w_bit & ~r_par_flag;
            PAR_ERR    <= r_par_flag;
            STP_ERR    <= ~w_bit;
            if (w_bit && !r_par_flag) P_DATA <= r_shift;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_edge_cnt <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: stimulus pushes expected frame results,
// a monitor pops and compares on every result pulse.
module tb_uart_rx_core;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  always #5 CLK = ~CLK;

  uart_rx_core #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
  } exp_t;

  exp_t       q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] last_good = 8'h00;

  task automatic push(input logic dv, input logic pe, input logic se, input logic [7:0] d);
    exp_t e;
    if (dv) last_good = d;
    e.dv = dv; e.pe = pe; e.se = se; e.pd = last_good;
    q.push_back(e);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    clks(p);
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic pbit, input logic stop);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pen) send_bit(pbit, p);
    send_bit(stop, p);
  endtask

  task automatic drain(input string name);
    clks(40);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: pending expected frames=%0d required=0", name, q.size());
    end
    q.delete();
  endtask

  // Monitor: every result pulse must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!RST && (DATA_VALID || PAR_ERR || STP_ERR)) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: dv=%b pe=%b se=%b p_data=%h required=no pulse",
                 DATA_VALID, PAR_ERR, STP_ERR, P_DATA);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({DATA_VALID, PAR_ERR, STP_ERR, P_DATA} !== {e.dv, e.pe, e.se, e.pd}) begin
          n_fail++;
          $display("FAIL frame: got dv=%b pe=%b se=%b p_data=%h required dv=%b pe=%b se=%b p_data=%h",
                   DATA_VALID, PAR_ERR, STP_ERR, P_DATA, e.dv, e.pe, e.se, e.pd);
        end else begin
          $display("[TB] frame ok: dv=%b pe=%b se=%b p_data=%h", DATA_VALID, PAR_ERR, STP_ERR, P_DATA);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clks(3);
    n_tests++;
    if ({DATA_VALID, PAR_ERR, STP_ERR, P_DATA} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got dv=%b pe=%b se=%b p_data=%h required all 0",
               DATA_VALID, PAR_ERR, STP_ERR, P_DATA);
    end
    RST = 1'b0;
    clks(10);

    // 1: even parity, 0xA6 (four ones -> parity 0)
    push(1'b1, 1'b0, 1'b0, 8'hA6);
    send_frame(8'hA6, 32, 1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 32);
    drain("t1");

    // 2: odd parity expects 1, send 0 -> parity error, P_DATA stays 0xA6
    PAR_TYP = 1'b1;
    push(1'b0, 1'b1, 1'b0, 8'h00);
    send_frame(8'hA6, 32, 1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 32);
    drain("t2");

    // 3: no parity, stop bit 0 on 0x5A, then a clean 0x3C
    PRESCALE = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    push(1'b0, 1'b0, 1'b1, 8'h00);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 48);
    push(1'b1, 1'b0, 1'b0, 8'h3C);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 16);
    drain("t3");

    // 4: 4-clock low glitch must be rejected
    PRESCALE = 6'd32;
    send_bit(1'b0, 4);
    send_bit(1'b1, 100);
    drain("t4");

    // 5: back-to-back frames at PRESCALE=8, even parity (all parity bits 0)
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    push(1'b1, 1'b0, 1'b0, 8'hAA);
    push(1'b1, 1'b0, 1'b0, 8'h05);
    push(1'b1, 1'b0, 1'b0, 8'hA6);
    send_frame(8'hAA, 8, 1'b1, 1'b0, 1'b1);
    send_frame(8'h05, 8, 1'b1, 1'b0, 1'b1);
    send_frame(8'hA6, 8, 1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 8);
    drain("t5");

    // 6: reset during data bit 3 of 0xFF, then clean 0x81
    PRESCALE = 6'd16; PAR_EN = 1'b0;
    send_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 8);
    RST = 1'b1;
    clks(1);
    n_tests++;
    if ({DATA_VALID, PAR_ERR, STP_ERR, P_DATA} !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_frame_reset: got dv=%b pe=%b se=%b p_data=%h required all 0",
               DATA_VALID, PAR_ERR, STP_ERR, P_DATA);
    end
    clks(2);
    RST = 1'b0;
    last_good = 8'h00;
    send_bit(1'b1, 64);
    push(1'b1, 1'b0, 1'b0, 8'h81);
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1, 16);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
